// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite channel bundle between one interconnect downstream port and a register slave.
interface axil_reg_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [RESP_WIDTH-1:0]   bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_WIDTH-1:0]   rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave (REG0/REG1 RW, WCNT, SUM); B one cycle after the completing AW/W handshake, R one cycle after AR.
// B and R are held until accepted; no new AW/W/AR is taken while a response is pending.
module axil_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int BASE_ADDR  = 0
) (
  input  logic            s_axi_aclk,
  input  logic            s_axi_areset,
  axil_reg_slave_if.slave s_axi
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_OFF = ADDR_WIDTH'(12);
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);
  localparam logic [RESP_WIDTH-1:0] RESP_DECERR = RESP_WIDTH'(3);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e              w_state_q;
  r_state_e              r_state_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic                  arready_q, rvalid_q;
  logic [RESP_WIDTH-1:0] bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0] reg0_q, reg0_d, reg1_q, reg1_d, wcnt_q, wcnt_d;

  // Out-of-range wins over misalignment; the counter and sum words are read-only.
  function automatic logic [RESP_WIDTH-1:0] decode(input logic [ADDR_WIDTH-1:0] off,
                                                   input logic is_write);
    if (off > LAST_OFF)                               decode = RESP_DECERR;
    else if (off[1:0] != 2'b00 || (is_write && off[3])) decode = RESP_SLVERR;
    else                                              decode = RESP_OKAY;
  endfunction

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = s_axi.awvalid & awready_q;
  assign w_hs  = s_axi.wvalid & wready_q;
  assign ar_hs = s_axi.arvalid & arready_q;

  logic                  commit_vld;
  logic [ADDR_WIDTH-1:0] commit_off;
  logic [DATA_WIDTH-1:0] commit_dat;
  logic [STRB_WIDTH-1:0] commit_strb;
  logic [RESP_WIDTH-1:0] commit_resp;

  // Address and data come either live from the bus or from whichever half was latched earlier.
  always_comb begin
    commit_vld  = 1'b0;
    commit_off  = s_axi.awaddr - BASE;
    commit_dat  = s_axi.wdata;
    commit_strb = s_axi.wstrb;
    unique case (w_state_q)
      W_IDLE:   commit_vld = aw_hs & w_hs;
      W_HAVE_A: begin
        commit_vld = w_hs;
        commit_off = waddr_q - BASE;
      end
      W_HAVE_D: begin
        commit_vld  = aw_hs;
        commit_dat  = wdata_q;
        commit_strb = wstrb_q;
      end
      default:  commit_vld = 1'b0;
    endcase
    commit_resp = decode(commit_off, 1'b1);
  end

  always_comb begin
    reg0_d = reg0_q;
    reg1_d = reg1_q;
    wcnt_d = wcnt_q;
    if (commit_vld && commit_resp == RESP_OKAY) begin
      wcnt_d = wcnt_q + DATA_WIDTH'(1);
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (commit_strb[i]) begin
          if (commit_off[2]) reg1_d[8*i +: 8] = commit_dat[8*i +: 8];
          else               reg0_d[8*i +: 8] = commit_dat[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      reg0_q <= '0;
      reg1_q <= '0;
      wcnt_q <= '0;
    end else begin
      reg0_q <= reg0_d;
      reg1_q <= reg1_d;
      wcnt_q <= wcnt_d;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else if (commit_vld) begin
      w_state_q <= W_RESP;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b1;
      bresp_q   <= commit_resp;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            w_state_q <= W_HAVE_A;
            waddr_q   <= s_axi.awaddr;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end else if (w_hs) begin
            w_state_q <= W_HAVE_D;
            wdata_q   <= s_axi.wdata;
            wstrb_q   <= s_axi.wstrb;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_HAVE_A: ;
        W_HAVE_D: ;
        W_RESP: begin
          if (s_axi.bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  logic [ADDR_WIDTH-1:0] rd_off;
  logic [RESP_WIDTH-1:0] rd_resp;
  logic [DATA_WIDTH-1:0] rd_word;

  // Reads sample the registers before any same-edge write lands.
  always_comb begin
    rd_off  = s_axi.araddr - BASE;
    rd_resp = decode(rd_off, 1'b0);
    rd_word = '0;
    unique case (rd_off[3:2])
      2'd0:    rd_word = reg0_q;
      2'd1:    rd_word = reg1_q;
      2'd2:    rd_word = wcnt_q;
      default: rd_word = reg0_q + reg1_q;
    endcase
    if (rd_resp != RESP_OKAY) rd_word = '0;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            r_state_q <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_word;
            rresp_q   <= rd_resp;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
endmodule

// File: tb/tb_axil_reg_slave.sv
// Randomised AXI4-Lite traffic against axil_reg_slave, checked by a word-level register model.
module tb_axil_reg_slave;
  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int RW   = 3;
  localparam int BASE = 0;
  localparam int TMO  = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axil_reg_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) s_axi ();

  axil_reg_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .BASE_ADDR(BASE)
  ) dut (
    .s_axi_aclk  (clk),
    .s_axi_areset(rst),
    .s_axi       (s_axi)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_reg [2];
  logic [31:0] m_wcnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_reg[0] = '0;
    m_reg[1] = '0;
    m_wcnt   = '0;
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [2:0] resp);
    int off;
    off = (int'(addr) - BASE) & 255;
    if (off > 12) resp = 3'd3;
    else if (off % 4 != 0 || off >= 8) resp = 3'd2;
    else begin
      resp = 3'd0;
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_reg[off/4][8*b +: 8] = data[8*b +: 8];
      m_wcnt = m_wcnt + 1;
    end
  endtask

  task automatic model_read(input logic [7:0] addr, output logic [31:0] d, output logic [2:0] r);
    int off;
    off = (int'(addr) - BASE) & 255;
    d = '0;
    if (off > 12) r = 3'd3;
    else if (off % 4 != 0) r = 3'd2;
    else begin
      r = 3'd0;
      case (off / 4)
        0:       d = m_reg[0];
        1:       d = m_reg[1];
        2:       d = m_wcnt;
        default: d = m_reg[0] + m_reg[1];
      endcase
    end
  endtask

  task automatic send_aw(input logic [7:0] addr, input int dly);
    int n;
    repeat (dly) @(negedge clk);
    s_axi.awaddr  = addr;
    s_axi.awvalid = 1'b1;
    n = 0;
    while (!s_axi.awready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check_eq("aw_timeout", 32'(s_axi.awready), 1);
    @(posedge clk); #1;
    s_axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    int n;
    repeat (dly) @(negedge clk);
    s_axi.wdata  = data;
    s_axi.wstrb  = strb;
    s_axi.wvalid = 1'b1;
    n = 0;
    while (!s_axi.wready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check_eq("w_timeout", 32'(s_axi.wready), 1);
    @(posedge clk); #1;
    s_axi.wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int hold);
    logic [2:0] exp_resp, got_resp;
    @(negedge clk);
    fork
      send_aw(addr, aw_dly);
      send_w(data, strb, w_dly);
    join
    check_eq("bvalid_latency", 32'(s_axi.bvalid), 1);
    model_write(addr, data, strb, exp_resp);
    got_resp = s_axi.bresp;
    repeat (hold) begin
      @(negedge clk);
      check_eq("bvalid_hold", 32'(s_axi.bvalid), 1);
      check_eq("bresp_hold", 32'(s_axi.bresp), 32'(got_resp));
      check_eq("awready_in_resp", 32'(s_axi.awready), 0);
      check_eq("wready_in_resp", 32'(s_axi.wready), 0);
    end
    s_axi.bready = 1'b1;
    @(posedge clk); #1;
    s_axi.bready = 1'b0;
    check_eq("bresp", 32'(got_resp), 32'(exp_resp));
  endtask

  task automatic do_read(input logic [7:0] addr, input int hold);
    logic [31:0] exp_d, got_d;
    logic [2:0]  exp_r, got_r;
    int n;
    @(negedge clk);
    model_read(addr, exp_d, exp_r);
    s_axi.araddr  = addr;
    s_axi.arvalid = 1'b1;
    n = 0;
    while (!s_axi.arready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check_eq("ar_timeout", 32'(s_axi.arready), 1);
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0;
    check_eq("rvalid_latency", 32'(s_axi.rvalid), 1);
    got_d = s_axi.rdata;
    got_r = s_axi.rresp;
    repeat (hold) begin
      @(negedge clk);
      check_eq("rvalid_hold", 32'(s_axi.rvalid), 1);
      check_eq("rdata_hold", s_axi.rdata, got_d);
      check_eq("rresp_hold", 32'(s_axi.rresp), 32'(got_r));
      check_eq("arready_in_data", 32'(s_axi.arready), 0);
    end
    s_axi.rready = 1'b1;
    @(posedge clk); #1;
    s_axi.rready = 1'b0;
    check_eq("rresp", 32'(got_r), 32'(exp_r));
    if (exp_r != 3'd2) check_eq("rdata", got_d, exp_d);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_awready"}, 32'(s_axi.awready), 0);
    check_eq({tag, "_wready"},  32'(s_axi.wready), 0);
    check_eq({tag, "_arready"}, 32'(s_axi.arready), 0);
    check_eq({tag, "_bvalid"},  32'(s_axi.bvalid), 0);
    check_eq({tag, "_rvalid"},  32'(s_axi.rvalid), 0);
    check_eq({tag, "_bresp"},   32'(s_axi.bresp), 0);
    check_eq({tag, "_rresp"},   32'(s_axi.rresp), 0);
    check_eq({tag, "_rdata"},   s_axi.rdata, 0);
  endtask

  function automatic logic [7:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 6)      return 8'(4 * $urandom_range(0, 3));
    else if (k < 8) return 8'(4 * $urandom_range(0, 2) + $urandom_range(1, 3));
    else            return 8'(16 + 4 * $urandom_range(0, 59));
  endfunction

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    s_axi.awaddr = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0;  s_axi.wstrb = '0; s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b0;
    s_axi.araddr = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("awready_after_reset", 32'(s_axi.awready), 1);
    check_eq("wready_after_reset",  32'(s_axi.wready), 1);
    check_eq("arready_after_reset", 32'(s_axi.arready), 1);

    // Directed scenarios
    do_write(8'h00, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(8'h00, 0);
    do_write(8'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(8'h04, 32'h12345678, 4'h3, 0, 3, 0);
    do_read(8'h04, 0);
    do_read(8'h08, 0);
    do_write(8'h00, 32'hFFFFFFFF, 4'hF, 2, 0, 0);
    do_write(8'h04, 32'h00000002, 4'hF, 0, 0, 0);
    do_read(8'h0C, 0);
    do_write(8'h08, 32'h0000ABCD, 4'hF, 0, 0, 0);
    do_read(8'h08, 0);
    do_read(8'h40, 0);
    do_read(8'h02, 0);
    do_write(8'h04, 32'hCAFEF00D, 4'hF, 1, 0, 5);
    do_read(8'h04, 5);

    // Same-edge read and write of REG0 must return the old value
    fork
      do_write(8'h00, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
      do_read(8'h00, 0);
    join
    do_read(8'h00, 0);

    // Reset while holding only the write address
    @(negedge clk);
    s_axi.awaddr = 8'h00; s_axi.awvalid = 1'b1;
    @(posedge clk); #1;
    s_axi.awvalid = 1'b0;
    check_eq("have_a_awready", 32'(s_axi.awready), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("midreset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    do_read(8'h00, 0);
    do_write(8'h00, 32'h0BADCAFE, 4'hF, 0, 0, 0);
    do_read(8'h00, 0);
    do_read(8'h08, 0);

    // Randomised traffic
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 2) != 2)
        do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(rand_addr(), $urandom_range(0, 2));
    end
    do_read(8'h00, 0);
    do_read(8'h04, 0);
    do_read(8'h08, 0);
    do_read(8'h0C, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
